ppu_requant: RTL and testbench
==============================

# ppu_requant

Post-processing unit that sits directly downstream of the accumulator collector. It consumes one 16-lane row of 24-bit signed partial sums per handshake (16 rows per tile) and applies a per-tile scale, rounding right shift, optional ReLU and int8 saturation. It emits packed int8 rows through a ready/valid output buffered by a small FIFO, and pulses a tile-done flag after the last row of each tile leaves.

## Interface
Parameters:
- LANES, 16, lanes per row
- PSUM_W, 24, signed partial-sum width per lane
- ROWS, 16, rows per tile
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 4)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_load  in  1  latch cfg_* (honoured only when idle)
- cfg_scale  in  16  unsigned multiplier
- cfg_shift  in  5  right-shift amount, 0..31
- cfg_relu  in  1  clamp negatives to zero
- in_valid  in  1  input row valid
- in_ready  out  1  block can accept a row
- in_data  in  LANES*PSUM_W  lane i at bits [i*24+23 : i*24]
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  LANES*8  lane i at bits [i*8+7 : i*8], two's complement
- tile_done  out  1  one-cycle pulse after the ROWS-th output handshake
- busy  out  1  any row in flight (S1, S2 or FIFO) or in_row_cnt != 0

## Operation
- Config registers: scale, shift, relu. Reset values: 1, 0, 0. Loaded on cfg_load when idle (busy == 0). cfg_load while busy is ignored; config never changes mid-tile.
- Input handshake: a row is accepted on an edge where in_valid && in_ready.
- in_ready = (fifo_count + s1_valid + s2_valid) < FIFO_DEPTH. The credit is conservative, so the FIFO can never overflow.
- Stage S1 (per lane), on acceptance: prod = signed(psum) * signed({1'b0, scale}). This is a 41-bit signed product, registered with s1_valid.
- Stage S2 (per lane):
  - shift == 0: r = prod.
  - otherwise: r = (prod + 2^(shift-1)) >>> shift, arithmetic shift, round half toward +inf.
  - If relu && r < 0: r = 0.
  - Saturate to [-128, 127].
  - Registered with s2_valid.
- FIFO: when s2_valid, the S2 row is written into the FIFO on the next edge. Read happens on out_valid && out_ready. Simultaneous read and write leaves fifo_count unchanged.
- out_valid = fifo_count != 0, and out_data is the FIFO head.
- Counters:
  - in_row_cnt increments on each accepted row and wraps ROWS-1 -> 0.
  - out_row_cnt increments on each output handshake and wraps ROWS-1 -> 0.
  - tile_done is registered and asserted for exactly one cycle after the edge where out_row_cnt wraps.
- No state machine beyond idle/busy. Tiles stream back-to-back with no bubble; cfg_load is only possible between tiles once the pipeline has drained.

## Timing
- Reset: in_ready=1, out_valid=0, out_data=0, tile_done=0, busy=0. FIFO, S1, S2 and both counters are cleared; config returns to 1/0/0.
- Reset asserted mid-tile discards all in-flight rows immediately (asynchronous reset).
- Latency: a row accepted at edge k is in S1 after k, in S2 after k+1, and is written to the FIFO at k+2. With an empty FIFO, out_valid is high during the cycle after edge k+2.
- Throughput: one row per cycle while out_ready is held high (steady-state credit 3 < 4).
- Backpressure: with out_ready=0, at most FIFO_DEPTH rows are accepted, then in_ready drops. in_ready rises again in the cycle after the first output handshake.
- Wrap boundaries:
  - in_row_cnt 15 -> 0 on the 16th acceptance.
  - tile_done is high during the cycle after the 16th output handshake, and never otherwise.
- out_data is stable while out_valid && !out_ready.

## Test plan
- Identity: after reset (scale=1, shift=0, relu=0), stream 16 rows with lane i = i-8 and out_ready=1. Required: out_data lane i = i-8; first out_valid 3 cycles after the first acceptance; tile_done one pulse after row 16; 16 consecutive valid cycles.
- Rounding/scale: cfg scale=3, shift=2. Required mappings:
  - psum 5 -> 15 -> (15+2)>>2 = 4
  - psum -5 -> -15 -> (-15+2)>>>2 = -4
  - psum 2 -> 6 -> 2
  - psum -2 -> -6 -> -1
- Saturation/ReLU: scale=1, shift=0, relu=1, lanes {8388607, -8388608, 127, -1, 128}. Required: {127, 0, 127, 0, 127}. Repeat with relu=0; required: {127, -128, 127, -1, 127}.
- Backpressure: out_ready=0 with in_valid held high. Required: exactly 4 rows accepted, then in_ready=0. Then set out_ready=1. Required: rows emerge in order, none lost or duplicated, and in_ready rises the cycle after the first read.
- Config lock: assert cfg_load with scale=7 mid-tile (busy=1). Required: the remaining rows still use the old scale. After drain (busy=0), cfg_load takes effect for the next tile.
- Reset mid-tile: after 5 rows accepted and 2 output, assert rst_n=0 for 1 cycle. Required: out_valid=0, tile_done=0, busy=0, in_ready=1. A following full 16-row tile produces exactly one tile_done.

Source files
------------

// File: rtl/ppu_requant.sv
// Post-processing requantiser: per-lane scale, rounding shift, optional ReLU and int8
// saturation on 16-lane partial-sum rows, with a credit-guarded output FIFO.
module ppu_requant #(
    parameter int LANES      = 16,
    parameter int PSUM_W     = 24,
    parameter int ROWS       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_load,
    input  logic [15:0]               cfg_scale,
    input  logic [4:0]                cfg_shift,
    input  logic                      cfg_relu,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*PSUM_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*8-1:0]        out_data,
    output logic                      tile_done,
    output logic                      busy
);

    localparam int PROD_W = PSUM_W + 17;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int RW     = $clog2(ROWS);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic signed [PROD_W:0] SAT_MAX = (PROD_W+1)'(127);
    localparam logic signed [PROD_W:0] SAT_MIN = (PROD_W+1)'(-128);

    logic [15:0] scale_q;
    logic [4:0]  shift_q;
    logic        relu_q;

    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_prod [LANES];
    logic                     s2_valid;
    logic [LANES*8-1:0]       s2_data;
    logic [LANES*8-1:0]       s2_next;

    logic [LANES*8-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        fifo_count;
    logic [AW:0]        credit;

    logic [RW-1:0] in_row_cnt;
    logic [RW-1:0] out_row_cnt;

    logic accept;
    logic rd_en;
    logic wr_en;

    // Round half toward +inf, optional ReLU, then clamp into int8.
    function automatic logic [7:0] requant(input logic signed [PROD_W-1:0] p,
                                           input logic [4:0] sh,
                                           input logic rl);
        logic signed [PROD_W:0] x;
        logic signed [PROD_W:0] bias;
        logic signed [PROD_W:0] r;
        logic [7:0] res;
        x    = {p[PROD_W-1], p};
        bias = '0;
        if (sh != 5'd0)
            bias = {{PROD_W{1'b0}}, 1'b1} << (sh - 5'd1);
        r = (x + bias) >>> sh;
        if (rl && r[PROD_W])
            r = '0;
        if (r > SAT_MAX)
            res = 8'h7f;
        else if (r < SAT_MIN)
            res = 8'h80;
        else
            res = r[7:0];
        return res;
    endfunction

    assign accept    = in_valid && in_ready;
    assign out_valid = (fifo_count != '0);
    assign rd_en     = out_valid && out_ready;
    assign wr_en     = s2_valid;
    assign out_data  = fifo_mem[rd_ptr];
    assign busy      = s1_valid || s2_valid || (fifo_count != '0) || (in_row_cnt != '0);

    // Every row already in S1/S2 owns a FIFO slot, so the FIFO cannot overflow.
    always_comb begin
        credit   = fifo_count + {{AW{1'b0}}, s1_valid} + {{AW{1'b0}}, s2_valid};
        in_ready = (credit < DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_q <= 16'd1;
            shift_q <= 5'd0;
            relu_q  <= 1'b0;
        end else if (cfg_load && !busy) begin
            scale_q <= cfg_scale;
            shift_q <= cfg_shift;
            relu_q  <= cfg_relu;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < LANES; i++)
                s1_prod[i] <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                for (int i = 0; i < LANES; i++)
                    s1_prod[i] <= PROD_W'($signed(in_data[i*PSUM_W +: PSUM_W]))
                                * PROD_W'($signed({1'b0, scale_q}));
            end
        end
    end

    always_comb begin
        s2_next = '0;
        for (int i = 0; i < LANES; i++)
            s2_next[i*8 +: 8] = requant(s1_prod[i], shift_q, relu_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_data <= s2_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_mem[i] <= '0;
        end else begin
            if (wr_en) begin
                fifo_mem[wr_ptr] <= s2_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)
                fifo_count <= fifo_count + 1'b1;
            else if (rd_en && !wr_en)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_row_cnt  <= '0;
            out_row_cnt <= '0;
            tile_done   <= 1'b0;
        end else begin
            if (accept)
                in_row_cnt <= (in_row_cnt == LAST_ROW) ? '0 : in_row_cnt + 1'b1;
            if (rd_en)
                out_row_cnt <= (out_row_cnt == LAST_ROW) ? '0 : out_row_cnt + 1'b1;
            tile_done <= rd_en && (out_row_cnt == LAST_ROW);
        end
    end

endmodule

// File: tb/tb_ppu_requant.sv
// Scoreboard bench for ppu_requant: expected rows are modelled at input acceptance and
// compared in order at each output handshake; scenarios cover config, saturation, flow control.
module tb_ppu_requant;

    localparam int LANES      = 16;
    localparam int PSUM_W     = 24;
    localparam int ROWS       = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int IW         = LANES*PSUM_W;
    localparam int OW         = LANES*8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_load;
    logic [15:0]   cfg_scale;
    logic [4:0]    cfg_shift;
    logic          cfg_relu;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          tile_done;
    logic          busy;

    int vectors = 0;
    int errors  = 0;

    logic [OW-1:0] exp_q[$];
    int m_scale = 1;
    int m_shift = 0;
    bit m_relu  = 1'b0;
    int hs_cnt   = 0;
    int td_total = 0;

    always #5 clk = ~clk;

    ppu_requant #(.LANES(LANES), .PSUM_W(PSUM_W), .ROWS(ROWS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_scale(cfg_scale),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .tile_done(tile_done), .busy(busy)
    );

    // Reference arithmetic: exact product, floor division with half-step bias.
    function automatic logic [7:0] model_lane(input int psum, input int sc, input int sh, input bit rl);
        longint p, d, q;
        p = longint'(psum) * longint'(sc);
        if (sh == 0) q = p;
        else begin
            d = longint'(1) << sh;
            q = p + d/2;
            if (q >= 0) q = q / d;
            else q = -((-q + d - 1) / d);
        end
        if (rl && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    function automatic logic [OW-1:0] model_row(input logic [IW-1:0] d);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[i*8 +: 8] = model_lane(int'($signed(d[i*PSUM_W +: PSUM_W])), m_scale, m_shift, m_relu);
        return r;
    endfunction

    function automatic logic [IW-1:0] rand_row();
        logic [IW-1:0] r;
        int v;
        for (int i = 0; i < LANES; i++) begin
            v = int'($urandom_range(400)) - 200;
            r[i*PSUM_W +: PSUM_W] = 24'(v);
        end
        return r;
    endfunction

    // Scoreboard monitor, tile_done timing model and output-hold check.
    initial begin
        logic [OW-1:0] expv;
        logic [OW-1:0] data_prev;
        bit td_next;
        bit stall_prev;
        td_next = 1'b0;
        stall_prev = 1'b0;
        data_prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hs_cnt = 0;
                td_next = 1'b0;
                stall_prev = 1'b0;
            end else begin
                vectors++;
                if (tile_done !== td_next) begin
                    errors++;
                    $display("[TB] FAIL tile_done_timing: got %b expected %b at %0t", tile_done, td_next, $time);
                end
                if (tile_done) td_total++;
                td_next = 1'b0;
                if (stall_prev) begin
                    vectors++;
                    if (out_valid !== 1'b1 || out_data !== data_prev) begin
                        errors++;
                        $display("[TB] FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, data_prev);
                    end
                end
                if (out_valid && out_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_row: got %h expected no output", out_data);
                    end else begin
                        expv = exp_q.pop_front();
                        if (out_data !== expv) begin
                            errors++;
                            $display("[TB] FAIL row_data: got %h expected %h", out_data, expv);
                        end
                    end
                    hs_cnt++;
                    if (hs_cnt == ROWS) begin
                        hs_cnt = 0;
                        td_next = 1'b1;
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back(model_row(in_data));
                stall_prev = out_valid && !out_ready;
                data_prev = out_data;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cfg_write(input logic [15:0] sc, input logic [4:0] sh, input logic rl);
        cfg_scale = sc; cfg_shift = sh; cfg_relu = rl; cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic drive_row(input logic [IW-1:0] d);
        int n = 0;
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else if (++n > 200) begin
                vectors++; errors++;
                $display("[TB] FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || out_valid) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (busy || out_valid) begin
            vectors++; errors++;
            $display("[TB] FAIL drain_timeout: got busy=%b expected 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic first_row_hold(input logic [IW-1:0] d, output logic [OW-1:0] got);
        int n = 0;
        out_ready = 1'b0;
        drive_row(d);
        @(negedge clk);
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) begin
            vectors++; errors++;
            $display("[TB] FAIL out_valid_timeout: got 0 expected 1");
        end
        got = out_data;
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_load = 1'b0; cfg_scale = '0; cfg_shift = '0; cfg_relu = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors += 5;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        if (tile_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_tile_done: got %b expected 0", tile_done); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        logic [IW-1:0] row;
        int first = -1, valid_run = 0, acc = 0, td_at = -1, td0;
        for (int i = 0; i < LANES; i++) row[i*PSUM_W +: PSUM_W] = 24'(i - 8);
        td0 = td_total;
        out_ready = 1'b1;
        for (int c = 0; c < 26; c++) begin
            in_valid = (c < 16);
            in_data = row;
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            if (out_valid) begin
                valid_run++;
                if (first < 0) first = c;
            end
            if (tile_done) td_at = c;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        vectors += 5;
        if (acc != 16) begin errors++; $display("[TB] FAIL identity_accepts: got %0d expected 16", acc); end
        if (first != 3) begin errors++; $display("[TB] FAIL identity_latency: got %0d expected 3", first); end
        if (valid_run != 16) begin errors++; $display("[TB] FAIL identity_valid_cycles: got %0d expected 16", valid_run); end
        if (td_at != 19) begin errors++; $display("[TB] FAIL identity_tile_done_cycle: got %0d expected 19", td_at); end
        if (td_total - td0 != 1) begin errors++; $display("[TB] FAIL identity_tile_done_count: got %0d expected 1", td_total - td0); end
    endtask

    task automatic test_rounding();
        logic [IW-1:0] row;
        logic [OW-1:0] got;
        cfg_write(16'd3, 5'd2, 1'b0);
        m_scale = 3; m_shift = 2; m_relu = 1'b0;
        row = rand_row();
        row[0*PSUM_W +: PSUM_W] = 24'(5);
        row[1*PSUM_W +: PSUM_W] = 24'(-5);
        row[2*PSUM_W +: PSUM_W] = 24'(2);
        row[3*PSUM_W +: PSUM_W] = 24'(-2);
        first_row_hold(row, got);
        vectors++;
        if (got[31:0] !== {8'hFF, 8'h02, 8'hFC, 8'h04}) begin
            errors++;
            $display("[TB] FAIL rounding_lanes: got %h expected ff02fc04", got[31:0]);
        end
        for (int k = 1; k < ROWS; k++) drive_row(rand_row());
        wait_idle();
    endtask

    task automatic test_sat_relu();
        int sv[5];
        logic [IW-1:0] row;
        logic [OW-1:0] got;
        logic [39:0] expv;
        sv = '{8388607, -8388608, 127, -1, 128};
        for (int pass = 0; pass < 2; pass++) begin
            cfg_write(16'd1, 5'd0, pass == 0);
            m_scale = 1; m_shift = 0; m_relu = (pass == 0);
            row = rand_row();
            for (int i = 0; i < 5; i++) row[i*PSUM_W +: PSUM_W] = 24'(sv[i]);
            first_row_hold(row, got);
            expv = (pass == 0) ? {8'd127, 8'h00, 8'd127, 8'h00, 8'd127}
                               : {8'd127, 8'hFF, 8'd127, 8'h80, 8'd127};
            vectors++;
            if (got[39:0] !== expv) begin
                errors++;
                $display("[TB] FAIL sat_relu_pass%0d: got %h expected %h", pass, got[39:0], expv);
            end
            for (int k = 1; k < ROWS; k++) drive_row(rand_row());
            wait_idle();
        end
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] rows[16];
        int idx = 0, n = 0;
        for (int k = 0; k < 16; k++) rows[k] = rand_row();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = rows[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 16) in_data = rows[idx]; else in_valid = 1'b0;
        end
        @(negedge clk);
        vectors += 2;
        if (idx != FIFO_DEPTH) begin errors++; $display("[TB] FAIL bp_accepted: got %0d expected %0d", idx, FIFO_DEPTH); end
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_low: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_before_read: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_in_ready_after_read: got %b expected 1", in_ready); end
        if (in_ready) idx++;
        @(posedge clk); #1;
        if (idx < 16) in_data = rows[idx]; else in_valid = 1'b0;
        while (idx < 16 && n < 200) begin
            n++;
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 16) in_data = rows[idx]; else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        wait_idle();
        vectors++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL bp_rows_lost: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_cfg_lock();
        cfg_write(16'd2, 5'd1, 1'b0);
        m_scale = 2; m_shift = 1; m_relu = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) drive_row(rand_row());
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL lock_busy_mid_tile: got %b expected 1", busy); end
        @(posedge clk); #1;
        cfg_write(16'd7, 5'd3, 1'b1);
        for (int k = 8; k < ROWS; k++) drive_row(rand_row());
        wait_idle();
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL lock_busy_after_drain: got %b expected 0", busy); end
        @(posedge clk); #1;
        cfg_write(16'd7, 5'd0, 1'b0);
        m_scale = 7; m_shift = 0; m_relu = 1'b0;
        for (int k = 0; k < ROWS; k++) drive_row(rand_row());
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int td0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) drive_row(rand_row());
        vectors++;
        if (hs_cnt != 2) begin errors++; $display("[TB] FAIL mid_outputs_before_reset: got %0d expected 2", hs_cnt); end
        out_ready = 1'b0;
        rst_n = 1'b0;
        m_scale = 1; m_shift = 0; m_relu = 1'b0;
        @(negedge clk);
        vectors += 4;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_out_valid: got %b expected 0", out_valid); end
        if (tile_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_tile_done: got %b expected 0", tile_done); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_after_release: got valid=%b busy=%b expected 0/0", out_valid, busy);
        end
        @(posedge clk); #1;
        td0 = td_total;
        out_ready = 1'b1;
        for (int k = 0; k < ROWS; k++) drive_row(rand_row());
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (td_total - td0 != 1) begin errors++; $display("[TB] FAIL mid_tile_done_count: got %0d expected 1", td_total - td0); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rounding();
        test_sat_relu();
        test_backpressure();
        test_cfg_lock();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL final_pending: got %0d expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
